// File: rtl/vga_pll_ctrl_pkg.sv
// Shared types for the VGA pixel PLL reset sequencer: FSM state encoding and timer sizing.
// The FAIL state is only reachable when VGA_PLL_FAIL_LIMIT_EN is defined.
package vga_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  // One shared timer covers every timed phase, so size it for the longest one.
  function automatic int unsigned timer_width(input int unsigned rst_cycles,
                                              input int unsigned lock_timeout,
                                              input int unsigned stable_cycles);
    int unsigned m;
    m = rst_cycles;
    if (lock_timeout > m) begin
      m = lock_timeout;
    end else begin
      m = m;
    end
    if (stable_cycles > m) begin
      m = stable_cycles;
    end else begin
      m = m;
    end
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/vga_pll_sync2.sv
// Generic two-flop synchronizer, asynchronous active-low reset to 0.
module vga_pll_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/vga_pll_reset_ctrl.sv
// Reset sequencer for the 108 MHz VGA pixel PLL, clocked by the 50 MHz refclk.
// Define VGA_PLL_FAIL_LIMIT_EN to stop retrying after MAX_RETRIES consecutive lock timeouts.
module vga_pll_reset_ctrl
  import vga_pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             soft_req,
  output logic             pll_rst,
  output logic             vga_rst_n,
  output logic             running,
  output logic             fail,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that saw lock counts as the first stable cycle.
  localparam logic [TW-1:0] STABLE_LAST = TW'((STABLE_CYCLES >= 2) ? (STABLE_CYCLES - 2) : 0);

  logic             lk_s;
  pll_state_e       state_q,     state_d;
  logic [TW-1:0]    timer_q,     timer_d;
  logic             pll_rst_q,   pll_rst_d;
  logic             vga_rst_n_q, vga_rst_n_d;
  logic             running_q,   running_d;
  logic [CNT_W-1:0] loss_cnt_q,  loss_cnt_d;

`ifdef VGA_PLL_FAIL_LIMIT_EN
  localparam int unsigned RW = $clog2(MAX_RETRIES) + 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
  logic [RW-1:0] retries_q, retries_d;
  logic          fail_q,    fail_d;
`endif

  vga_pll_sync2 u_lock_sync (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (lk_s)
  );

  // Next-state, timer, counters and the output decode of the next state.
  always_comb begin
    state_d    = state_q;
    loss_cnt_d = loss_cnt_q;
`ifdef VGA_PLL_FAIL_LIMIT_EN
    retries_d  = retries_q;
`endif
    if (soft_req) begin
      state_d = RST_HOLD;
`ifdef VGA_PLL_FAIL_LIMIT_EN
      retries_d = '0;
`endif
    end else begin
      case (state_q)
        RST_HOLD: begin
          if (timer_q == RST_LAST) state_d = WAIT_LOCK;
          else                     state_d = RST_HOLD;
        end
        WAIT_LOCK: begin
          if (lk_s) begin
            state_d = STABLE;
          end else if (timer_q == LOCK_LAST) begin
`ifdef VGA_PLL_FAIL_LIMIT_EN
            if (retries_q == RETRY_LAST) begin
              state_d = FAIL;
            end else begin
              state_d   = RST_HOLD;
              retries_d = retries_q + RW'(1);
            end
`else
            state_d = RST_HOLD;
`endif
          end else begin
            state_d = WAIT_LOCK;
          end
        end
        STABLE: begin
          if (!lk_s) begin
            state_d = WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d = RUN;
`ifdef VGA_PLL_FAIL_LIMIT_EN
            retries_d = '0;
`endif
          end else begin
            state_d = STABLE;
          end
        end
        RUN: begin
          if (!lk_s) begin
            state_d = RST_HOLD;
            if (loss_cnt_q != {CNT_W{1'b1}}) loss_cnt_d = loss_cnt_q + CNT_W'(1);
            else                             loss_cnt_d = loss_cnt_q;
          end else begin
            state_d = RUN;
          end
        end
        FAIL: begin
`ifdef VGA_PLL_FAIL_LIMIT_EN
          state_d = FAIL;
`else
          state_d = RST_HOLD;
`endif
        end
        default: state_d = RST_HOLD;
      endcase
    end

    // soft_req restarts the hold even when already in RST_HOLD.
    if (soft_req || (state_d != state_q)) begin
      timer_d = '0;
    end else if ((state_q == RST_HOLD) || (state_q == WAIT_LOCK) || (state_q == STABLE)) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end

    pll_rst_d   = (state_d == RST_HOLD) || (state_d == FAIL);
    vga_rst_n_d = (state_d == RUN);
    running_d   = (state_d == RUN);
`ifdef VGA_PLL_FAIL_LIMIT_EN
    fail_d      = (state_d == FAIL);
`endif
  end

  // State and registered outputs; reset holds the PLL in reset immediately.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_HOLD;
      timer_q     <= '0;
      pll_rst_q   <= 1'b1;
      vga_rst_n_q <= 1'b0;
      running_q   <= 1'b0;
      loss_cnt_q  <= '0;
`ifdef VGA_PLL_FAIL_LIMIT_EN
      retries_q   <= '0;
      fail_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pll_rst_q   <= pll_rst_d;
      vga_rst_n_q <= vga_rst_n_d;
      running_q   <= running_d;
      loss_cnt_q  <= loss_cnt_d;
`ifdef VGA_PLL_FAIL_LIMIT_EN
      retries_q   <= retries_d;
      fail_q      <= fail_d;
`endif
    end
  end

  assign pll_rst       = pll_rst_q;
  assign vga_rst_n     = vga_rst_n_q;
  assign running       = running_q;
  assign lock_loss_cnt = loss_cnt_q;
`ifdef VGA_PLL_FAIL_LIMIT_EN
  assign fail          = fail_q;
`else
  assign fail          = 1'b0;
`endif

endmodule
